adder_i4_o3_err_sweep_ctrl: RTL and testbench

//  Sequencer that sweeps all 2^N_IN input vectors through an external combinational approximate adder.

---
 rtl/adder_i4_o3_err_sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_adder_i4_o3_err_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_i4_o3_err_sweep_ctrl.sv
// Sweeps all 2^N_IN vectors through an external approximate adder, SETTLE+1 cycles per vector; start ignored unless IDLE.
// ERR_SWEEP_EARLY_ABORT_EN: the first sampled vector with err > ET ends the sweep with fail set.
module adder_i4_o3_err_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int ET     = 5,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN-1:0]        dut_in,
  input  logic [N_IN/2:0]        dut_out,
  output logic [N_IN/2:0]        err_max,
  output logic [N_IN+N_IN/2:0]   err_sum,
  output logic [N_IN:0]          mism_cnt,
  output logic [N_IN:0]          vec_cnt,
  output logic                   fail
);

  localparam int OPW   = N_IN / 2;
  localparam int N_OUT = OPW + 1;
  localparam int SUMW  = N_IN + N_OUT;
  localparam int CNTW  = N_IN + 1;
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned ET_U = ET;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_FIN} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     hold_cnt;
  logic [N_IN-1:0]   idx;
  logic [OPW-1:0]    op_a, op_b;
  logic [N_OUT-1:0]  exact, err, max_nxt;
  logic              accept, last_vec, abort, finish;

  assign dut_in   = idx;
  assign op_a     = idx[OPW-1:0];
  assign op_b     = idx[N_IN-1:OPW];
  assign exact    = N_OUT'(op_a) + N_OUT'(op_b);
  assign err      = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
  assign max_nxt  = (err > err_max) ? err : err_max;
  assign last_vec = (idx == '1);

`ifdef ERR_SWEEP_EARLY_ABORT_EN
  assign abort = (32'(err) > ET_U);
`else
  assign abort = 1'b0;
`endif

  assign finish = last_vec || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        busy = 1'b1;
        if (hold_cnt == SW'(SETTLE - 1)) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy      = 1'b1;
        state_nxt = finish ? ST_FIN : ST_DRIVE;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stats and fail persist through FIN/IDLE until the next accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      hold_cnt <= '0;
      err_max  <= '0;
      err_sum  <= '0;
      mism_cnt <= '0;
      vec_cnt  <= '0;
      fail     <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      hold_cnt <= '0;
      err_max  <= '0;
      err_sum  <= '0;
      mism_cnt <= '0;
      vec_cnt  <= '0;
      fail     <= 1'b0;
    end else begin
      case (state)
        ST_DRIVE: hold_cnt <= hold_cnt + 1'b1;
        ST_SAMPLE: begin
          hold_cnt <= '0;
          err_max  <= max_nxt;
          err_sum  <= err_sum + SUMW'(err);
          mism_cnt <= mism_cnt + CNTW'(err != '0);
          vec_cnt  <= vec_cnt + 1'b1;
          if (finish) fail <= (32'(max_nxt) > ET_U);
          else        idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_i4_o3_err_sweep_ctrl.sv
// Bench for the approximate-adder sweep controller: models the external adder and scoreboards sweep results.
module tb_adder_i4_o3_err_sweep_ctrl;

  localparam int ET = 5;

  typedef struct packed {
    logic [2:0] emax;
    logic [6:0] esum;
    logic [4:0] mism;
    logic [4:0] vec;
    logic       fail;
  } res_t;

  typedef struct {
    res_t res;
    int   cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  int   mode = 0;

  logic       busy0, done0, fail0, busy1, done1, fail1;
  logic [3:0] din0, din1;
  logic [2:0] dout0, dout1, emax0, emax1;
  logic [6:0] esum0, esum1;
  logic [4:0] mism0, mism1, vec0, vec1;

  res_t       got;
  logic       obs_busy, obs_done;
  logic [3:0] obs_din;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adder_i4_o3_err_sweep_ctrl #(.N_IN(4), .ET(ET), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .busy(busy0), .done(done0),
    .dut_in(din0), .dut_out(dout0), .err_max(emax0), .err_sum(esum0),
    .mism_cnt(mism0), .vec_cnt(vec0), .fail(fail0));

  adder_i4_o3_err_sweep_ctrl #(.N_IN(4), .ET(ET), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .busy(busy1), .done(done1),
    .dut_in(din1), .dut_out(dout1), .err_max(emax1), .err_sum(esum1),
    .mism_cnt(mism1), .vec_cnt(vec1), .fail(fail1));

  // External adder under characterisation: 0 exact, 1 stuck-0, 2 stuck-7, else OR-approximation.
  function automatic logic [2:0] model_out(input int m, input logic [3:0] v);
    logic [1:0] a, b;
    a = v[1:0];
    b = v[3:2];
    case (m)
      0:       model_out = {1'b0, a} + {1'b0, b};
      1:       model_out = 3'd0;
      2:       model_out = 3'd7;
      default: model_out = {1'b0, a | b};
    endcase
  endfunction

  function automatic exp_t model_sweep(input int m, input int s);
    exp_t e;
    int   ex, d;
    e.res = '0;
    for (int v = 0; v < 16; v++) begin
      ex = (v % 4) + (v / 4);
      d  = int'(model_out(m, 4'(v))) - ex;
      if (d < 0) d = -d;
      if (d > int'(e.res.emax)) e.res.emax = 3'(d);
      e.res.esum = e.res.esum + 7'(d);
      if (d != 0) e.res.mism = e.res.mism + 5'd1;
      e.res.vec = e.res.vec + 5'd1;
`ifdef ERR_SWEEP_EARLY_ABORT_EN
      if (d > ET) break;
`endif
    end
    e.res.fail = (int'(e.res.emax) > ET);
    e.cycles   = int'(e.res.vec) * (s + 1);
    return e;
  endfunction

  always_comb begin
    dout0 = model_out(mode, din0);
    dout1 = model_out(mode, din1);
  end

  assign got      = sel ? {emax1, esum1, mism1, vec1, fail1} : {emax0, esum0, mism0, vec0, fail0};
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_done = sel ? done1 : done0;
  assign obs_din  = sel ? din1 : din0;

  // Launch one sweep, push its expectation, and follow it to a few cycles past done.
  task automatic run_sweep(input bit use1, input int m, input int poke_at,
                           output int cyc, output bit seq_ok, output int n_done);
    int s;
    int ex;
    s = use1 ? 3 : 1;
    sel = use1;
    mode = m;
    cyc = 0;
    seq_ok = 1'b1;
    n_done = 0;
    sb.push_back(model_sweep(m, s));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      start = (k == poke_at);
      ex = k / (s + 1);
      if (ex > 15) ex = 15;
      if (obs_done) begin
        n_done++;
        if (cyc == 0) cyc = k;
      end else if (cyc == 0) begin
        if (!obs_busy || obs_din != 4'(ex)) seq_ok = 1'b0;
      end else if (obs_busy) begin
        seq_ok = 1'b0;
      end
      if (cyc != 0 && k >= cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({busy0, done0, busy1, done1} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctl got=%b want=0000", {busy0, done0, busy1, done1});
    end
    n_vec++;
    if ({din0, din1} !== 8'h00) begin
      n_err++; $display("FAIL reset_dut_in got=%h want=00", {din0, din1});
    end
    n_vec++;
    if ({emax0, esum0, mism0, vec0, fail0} !== 21'd0) begin
      n_err++; $display("FAIL reset_stats got=%h want=0", {emax0, esum0, mism0, vec0, fail0});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic sweep_and_score(input string name, input bit use1, input int m, input int poke_at);
    int   cyc, n_done;
    bit   seq_ok;
    exp_t e;
    run_sweep(use1, m, poke_at, cyc, seq_ok, n_done);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== e.cycles) begin
      n_err++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, e.cycles);
    end
    n_vec++;
    if (got !== e.res) begin
      n_err++; $display("FAIL %s_stats got=%h want=%h", name, got, e.res);
    end
    n_vec++;
    if (n_done !== 1) begin
      n_err++; $display("FAIL %s_done_pulses got=%0d want=1", name, n_done);
    end
    n_vec++;
    if (seq_ok !== 1'b1) begin
      n_err++; $display("FAIL %s_sequence got=%b want=1", name, seq_ok);
    end
  endtask

  task automatic test_exact();       sweep_and_score("exact", 1'b0, 0, 0);    endtask
  task automatic test_stuck0();      sweep_and_score("stuck0", 1'b0, 1, 0);   endtask
  task automatic test_stuck7();      sweep_and_score("stuck7", 1'b0, 2, 0);   endtask
  task automatic test_or_approx();   sweep_and_score("or_approx", 1'b0, 3, 0); endtask
  task automatic test_start_ignored(); sweep_and_score("restart", 1'b0, 0, 10); endtask
  task automatic test_settle3();     sweep_and_score("settle3", 1'b1, 0, 0);  endtask

  task automatic test_midsweep_reset();
    sel = 1'b0;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy0, done0} !== 2'b00) begin
      n_err++; $display("FAIL midreset_ctl got=%b want=00", {busy0, done0});
    end
    n_vec++;
    if (din0 !== 4'h0) begin
      n_err++; $display("FAIL midreset_dut_in got=%h want=0", din0);
    end
    n_vec++;
    if (got !== res_t'(0)) begin
      n_err++; $display("FAIL midreset_stats got=%h want=0", got);
    end
    @(negedge clk) rst_n = 1'b1;
    sweep_and_score("post_reset", 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int   d1, d2;
    res_t r1, r2;
    exp_t e1, e2;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    sel = 1'b0;
    mode = 3;
    sb.push_back(model_sweep(3, 1));
    sb.push_back(model_sweep(3, 1));
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        if (d1 == 0) begin d1 = k; r1 = got; end
        else begin d2 = k; r2 = got; break; end
      end
    end
    start = 1'b0;
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    n_vec++;
    if (d1 !== e1.cycles) begin
      n_err++; $display("FAIL b2b_first_latency got=%0d want=%0d", d1, e1.cycles);
    end
    n_vec++;
    if (d2 !== e1.cycles + 2 + e2.cycles) begin
      n_err++; $display("FAIL b2b_second_latency got=%0d want=%0d", d2, e1.cycles + 2 + e2.cycles);
    end
    n_vec++;
    if (r1 !== e1.res) begin
      n_err++; $display("FAIL b2b_first_stats got=%h want=%h", r1, e1.res);
    end
    n_vec++;
    if (r2 !== e2.res) begin
      n_err++; $display("FAIL b2b_second_stats got=%h want=%h", r2, e2.res);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_stuck0();
    test_stuck7();
    test_or_approx();
    test_start_ignored();
    test_midsweep_reset();
    test_settle3();
    test_back_to_back();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
